counter_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 8-bit counter between four requesters. Each requester posts a counter operation (increment, decrement, clear, no-op) with a req/ack handshake. The block grants one requester at a time, applies its operation to the shared counter and acknowledges it. It also drives a combinational `valid` property output for the formal flow, alongside the counter value.

---
 rtl/counter_arbiter_if.sv | 25 ++
 rtl/counter_arbiter.sv | 115 +++++++++++
 tb/tb_counter_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/counter_arbiter_if.sv
// Handshake bundle between the four counter requesters and the shared-counter arbiter.
// The master side is the requesters; the slave side is counter_arbiter.
interface counter_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]   req;
   logic [2*N_REQ-1:0] op;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   ack;
   logic               busy;
   logic [WIDTH-1:0]   count;
   logic               overflow;
   logic               valid;

   modport master (
      output req, op,
      input  gnt, ack, busy, count, overflow, valid
   );

   modport slave (
      input  req, op,
      output gnt, ack, busy, count, overflow, valid
   );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin arbiter serialising INC/DEC/CLR/NOP requests from four requesters onto
// one shared counter: IDLE picks a winner, EXEC applies its op, ACK pulses the acknowledge.
module counter_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   counter_arbiter_if.slave bus
);
   localparam logic [1:0] OP_INC = 2'b00;
   localparam logic [1:0] OP_DEC = 2'b01;
   localparam logic [1:0] OP_CLR = 2'b10;

   typedef enum logic [1:0] {IDLE, EXEC, ACKS} state_t;

   state_t           state_reg;
   logic [1:0]       ptr_reg;
   logic [1:0]       win_reg;
   logic [1:0]       wop_reg;
   logic [N_REQ-1:0] gnt_reg;
   logic [N_REQ-1:0] ack_reg;
   logic             busy_reg;
   logic [WIDTH-1:0] count_reg;
   logic             overflow_reg;

   logic [1:0]       op_lane [N_REQ];
   logic [1:0]       pick_idx;
   logic [1:0]       cand;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_op_lane
         assign op_lane[gi] = bus.op[2*gi+1 : 2*gi];
      end
   endgenerate

   // Scan from the farthest candidate back to ptr so the one nearest ptr wins.
   always_comb begin
      pick_idx = ptr_reg;
      cand     = ptr_reg;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr_reg + 2'(k);
         if (bus.req[cand]) begin
            pick_idx = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         win_reg      <= '0;
         wop_reg      <= '0;
         gnt_reg      <= '0;
         ack_reg      <= '0;
         busy_reg     <= 1'b0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            IDLE: begin
               if (|bus.req) begin
                  win_reg   <= pick_idx;
                  wop_reg   <= op_lane[pick_idx];
                  gnt_reg   <= N_REQ'(1) << pick_idx;
                  busy_reg  <= 1'b1;
                  state_reg <= EXEC;
               end
            end
            EXEC: begin
               case (wop_reg)
                  OP_INC: begin
                     count_reg <= count_reg + WIDTH'(1);
                     if (count_reg == '1) overflow_reg <= 1'b1;
                  end
                  OP_DEC: begin
                     count_reg <= count_reg - WIDTH'(1);
                     if (count_reg == '0) overflow_reg <= 1'b1;
                  end
                  OP_CLR: begin
                     count_reg    <= '0;
                     overflow_reg <= 1'b0;
                  end
                  default: ;
               endcase
               ack_reg   <= N_REQ'(1) << win_reg;
               gnt_reg   <= '0;
               ptr_reg   <= win_reg + 2'd1;
               state_reg <= ACKS;
            end
            ACKS: begin
               ack_reg   <= '0;
               busy_reg  <= 1'b0;
               state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   function automatic logic onehot0(input logic [N_REQ-1:0] v);
      return (v & (v - N_REQ'(1))) == '0;
   endfunction

   assign bus.gnt      = gnt_reg;
   assign bus.ack      = ack_reg;
   assign bus.busy     = busy_reg;
   assign bus.count    = count_reg;
   assign bus.overflow = overflow_reg;
   assign bus.valid    = onehot0(gnt_reg) && onehot0(ack_reg)
                         && !((|gnt_reg) && (|ack_reg))
                         && (busy_reg == ((|gnt_reg) || (|ack_reg)));
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: stimulus pushes the expected ack/count/overflow
// into a queue, and a negedge monitor pops and compares every ack pulse.
module tb_counter_arbiter;
   localparam logic [1:0] INC = 2'b00;
   localparam logic [1:0] DEC = 2'b01;
   localparam logic [1:0] CLR = 2'b10;
   localparam logic [1:0] NOP = 2'b11;

   typedef struct packed {
      logic [3:0] ack;
      logic [7:0] count;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   counter_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

   counter_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input int i, input logic [7:0] c, input logic o);
      exp_t e;
      e.ack   = 4'(1) << i;
      e.count = c;
      e.ovf   = o;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input int i);
      bit seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (bus.ack[i]) seen = 1'b1;
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL ack_timeout: requester %0d got no ack, expected one within 20 cycles", i);
      end
   endtask

   task automatic serve(input int i, input logic [1:0] opc, input logic [7:0] c, input logic o);
      push(i, c, o);
      @(negedge clk);
      bus.req[i]        = 1'b1;
      bus.op[2*i +: 2]  = opc;
      wait_ack(i);
      bus.req[i] = 1'b0;
      @(negedge clk);
      $display("served req %0d op %b -> count %0h ovf %0b", i, opc, bus.count, bus.overflow);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: invariants every cycle, expectation popped on each ack pulse.
   always @(negedge clk) begin
      exp_t e;
      check("valid", 32'(bus.valid), 32'd1);
      if (bus.ack != 4'b0000) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ack: got ack=%b, expected no ack", bus.ack);
         end else begin
            e = sb.pop_front();
            check("ack", 32'(bus.ack), 32'(e.ack));
            check("count", 32'(bus.count), 32'(e.count));
            check("overflow", 32'(bus.overflow), 32'(e.ovf));
            $display("ack %b count %0h ovf %0b", bus.ack, bus.count, bus.overflow);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] rr;
      int         acks;

      bus.req = '0;
      bus.op  = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_count", 32'(bus.count), 32'd0);
      check("rst_ovf", 32'(bus.overflow), 32'd0);
      rst = 1'b0;

      // Single INC from requester 2: gnt at t+1, ack/count at t+2, idle at t+3.
      @(negedge clk);
      push(2, 8'd1, 1'b0);
      bus.req[2]   = 1'b1;
      bus.op[5:4]  = INC;
      @(negedge clk);
      check("s1_gnt", 32'(bus.gnt), 32'b0100);
      check("s1_busy_exec", 32'(bus.busy), 32'd1);
      wait_ack(2);
      bus.req[2] = 1'b0;
      @(negedge clk);
      check("s1_busy_idle", 32'(bus.busy), 32'd0);

      // Four requesters contending, each re-raising one cycle after its ack.
      do_reset();
      for (int k = 0; k < 6; k++) push(k % 4, 8'(k + 1), 1'b0);
      bus.op  = '0;
      bus.req = 4'b1111;
      rr      = '0;
      acks    = 0;
      for (int cyc = 0; cyc < 60 && acks < 6; cyc++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (rr[i]) begin
               bus.req[i] = 1'b1;
               rr[i]      = 1'b0;
            end else if (bus.ack[i]) begin
               bus.req[i] = 1'b0;
               rr[i]      = 1'b1;
               acks++;
            end
         end
      end
      bus.req = '0;
      check("rr_acks", 32'(acks), 32'd6);
      check("rr_count", 32'(bus.count), 32'd6);
      @(negedge clk);

      // Wrap in both directions, then clear.
      do_reset();
      serve(0, DEC, 8'hFF, 1'b1);
      serve(0, INC, 8'h00, 1'b1);
      serve(0, CLR, 8'h00, 1'b0);
      serve(0, NOP, 8'h00, 1'b0);

      // Pointer after requester 1 is 2, so 0011 must grant 0, then 1.
      serve(1, INC, 8'd1, 1'b0);
      push(0, 8'd2, 1'b0);
      push(1, 8'd3, 1'b0);
      @(negedge clk);
      bus.op  = '0;
      bus.req = 4'b0011;
      @(negedge clk);
      check("ptr_gnt0", 32'(bus.gnt), 32'b0001);
      wait_ack(0);
      bus.req[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("ptr_gnt1", 32'(bus.gnt), 32'b0010);
      wait_ack(1);
      bus.req[1] = 1'b0;
      @(negedge clk);

      // Reset mid-EXEC discards the in-flight INC; requester 3 is re-granted afterwards.
      serve(2, INC, 8'd4, 1'b0);
      serve(2, INC, 8'd5, 1'b0);
      @(negedge clk);
      bus.req[3]  = 1'b1;
      bus.op[7:6] = INC;
      @(negedge clk);
      check("mid_gnt", 32'(bus.gnt), 32'b1000);
      check("mid_count", 32'(bus.count), 32'd5);
      #2 rst = 1'b1;
      #1;
      check("arst_gnt", 32'(bus.gnt), 32'd0);
      check("arst_ack", 32'(bus.ack), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_count", 32'(bus.count), 32'd0);
      check("arst_valid", 32'(bus.valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      push(3, 8'd1, 1'b0);
      @(negedge clk);
      check("post_rst_gnt", 32'(bus.gnt), 32'b1000);
      wait_ack(3);
      bus.req[3] = 1'b0;
      @(negedge clk);

      // op flips to CLR during EXEC; the latched INC must still be applied.
      push(0, 8'd2, 1'b0);
      @(negedge clk);
      bus.req[0]  = 1'b1;
      bus.op[1:0] = INC;
      @(negedge clk);
      bus.op[1:0] = CLR;
      check("latch_gnt", 32'(bus.gnt), 32'b0001);
      wait_ack(0);
      bus.req[0] = 1'b0;
      bus.op     = '0;

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
